// File: rtl/fpr_cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fpr_cdb_arbiter_if
// Brief    : Dispatch handshake and FPR CDB broadcast bundle between the FP
//            execute units and the CDB arbiter.
// Revision : 1.0
// ============================================================================
interface fpr_cdb_arbiter_if #(
    parameter int N_UNIT    = 3,
    parameter int ROB_WIDTH = 6
);
    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    logic [N_UNIT-1:0]           req_valid;
    logic [N_UNIT-1:0]           req_ready;
    logic [N_UNIT*ROB_WIDTH-1:0] unit_tag;
    logic [N_UNIT*32-1:0]        unit_result;
    cdb_t                        fpr_cdb;

    modport master (
        input  req_valid,
        input  unit_tag,
        input  unit_result,
        output req_ready,
        output fpr_cdb
    );

    modport slave (
        output req_valid,
        output unit_tag,
        output unit_result,
        input  req_ready,
        input  fpr_cdb
    );
endinterface
`default_nettype wire

// File: rtl/fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpr_cdb_arbiter
// Brief    : Reserves fixed-latency CDB slots for FP execute units and
//            broadcasts {tag, result} when each granted op completes.
// Revision : 1.0
// ============================================================================
module fpr_cdb_arbiter #(
    parameter int                  N_UNIT    = 3,
    parameter int                  MAX_LAT   = 8,
    parameter logic [4*N_UNIT-1:0] LATENCY   = {4'd1, 4'd3, 4'd2},
    parameter int                  ROB_WIDTH = 6
) (
    input  wire logic         clk,
    input  wire logic         reset,
    fpr_cdb_arbiter_if.master bus
);

    localparam int c_PTR_W = (N_UNIT > 1) ? $clog2(N_UNIT) : 1;

    function automatic int lat_of(input int u);
        return int'(LATENCY[4*u +: 4]);
    endfunction

    logic [MAX_LAT:1]       r_slot_vld;
    logic [c_PTR_W-1:0]     r_slot_unit [1:MAX_LAT];
    logic [ROB_WIDTH-1:0]   r_slot_tag  [1:MAX_LAT];
    logic [c_PTR_W-1:0]     r_rr_ptr;

    logic [N_UNIT-1:0]      w_free;
    logic [N_UNIT-1:0]      w_elig;
    logic [N_UNIT-1:0]      w_grant;
    logic [c_PTR_W-1:0]     w_pos [N_UNIT];
    logic                   w_any;
    logic [c_PTR_W-1:0]     w_last_pos;
    logic [c_PTR_W-1:0]     w_rr_next;
    logic [31:0]            w_data;

    // A unit's landing slot is free after the shift if the entry behind it is empty.
    generate
        for (genvar gi = 0; gi < N_UNIT; gi++) begin : g_unit
            localparam int c_L = lat_of(gi);
            if (c_L < 1 || c_L > MAX_LAT) begin : g_bad_lat
                $error("fpr_cdb_arbiter: LATENCY of a unit is outside 1..MAX_LAT");
            end
            if (c_L >= MAX_LAT) begin : g_free_top
                assign w_free[gi] = 1'b1;
            end else begin : g_free_mid
                assign w_free[gi] = ~r_slot_vld[c_L+1];
            end
        end
    endgenerate

    assign w_elig = bus.req_valid & w_free;

    // Position of each unit in this cycle's round-robin scan (0 = first).
    always_comb begin
        for (int i = 0; i < N_UNIT; i++) begin
            if (c_PTR_W'(i) >= r_rr_ptr) begin
                w_pos[i] = c_PTR_W'(i) - r_rr_ptr;
            end else begin
                w_pos[i] = c_PTR_W'(i + N_UNIT) - r_rr_ptr;
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_any      = 1'b0;
        w_last_pos = '0;
        w_rr_next  = r_rr_ptr;
        for (int i = 0; i < N_UNIT; i++) begin
            w_grant[i] = w_elig[i] & ~reset;
            for (int j = 0; j < N_UNIT; j++) begin
                if (j != i && lat_of(j) == lat_of(i) && w_elig[j] && w_pos[j] < w_pos[i]) begin
                    w_grant[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < N_UNIT; i++) begin
            if (w_grant[i] && (!w_any || w_pos[i] > w_last_pos)) begin
                w_any      = 1'b1;
                w_last_pos = w_pos[i];
                w_rr_next  = (i == N_UNIT - 1) ? '0 : c_PTR_W'(i + 1);
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N_UNIT; i++) begin
            if (r_slot_unit[1] == c_PTR_W'(i)) begin
                w_data = bus.unit_result[32*i +: 32];
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.fpr_cdb   = {r_slot_vld[1], r_slot_tag[1], w_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= '0;
            r_rr_ptr   <= '0;
            for (int k = 1; k <= MAX_LAT; k++) begin
                r_slot_unit[k] <= '0;
                r_slot_tag[k]  <= '0;
            end
        end else begin
            for (int k = 1; k < MAX_LAT; k++) begin
                r_slot_vld[k]  <= r_slot_vld[k+1];
                r_slot_unit[k] <= r_slot_unit[k+1];
                r_slot_tag[k]  <= r_slot_tag[k+1];
            end
            r_slot_vld[MAX_LAT] <= 1'b0;
            // Grants land after the shift; same-latency grants never collide.
            for (int i = 0; i < N_UNIT; i++) begin
                if (w_grant[i]) begin
                    r_slot_vld[lat_of(i)]  <= 1'b1;
                    r_slot_unit[lat_of(i)] <= c_PTR_W'(i);
                    r_slot_tag[lat_of(i)]  <= bus.unit_tag[ROB_WIDTH*i +: ROB_WIDTH];
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpr_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpr_cdb_arbiter
// Brief    : Directed scoreboard bench for fpr_cdb_arbiter (default latencies
//            plus an all-latency-2 instance for round-robin behaviour).
// Revision : 1.0
// ============================================================================
module tb_fpr_cdb_arbiter;

    localparam int N_UNIT    = 3;
    localparam int ROB_WIDTH = 6;

    logic clk = 1'b0;
    logic reset;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpr_cdb_arbiter_if #(.N_UNIT(N_UNIT), .ROB_WIDTH(ROB_WIDTH)) bus_a ();
    fpr_cdb_arbiter_if #(.N_UNIT(N_UNIT), .ROB_WIDTH(ROB_WIDTH)) bus_b ();

    fpr_cdb_arbiter #(
        .N_UNIT(N_UNIT), .MAX_LAT(8), .LATENCY({4'd1, 4'd3, 4'd2}), .ROB_WIDTH(ROB_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    fpr_cdb_arbiter #(
        .N_UNIT(N_UNIT), .MAX_LAT(8), .LATENCY({4'd2, 4'd2, 4'd2}), .ROB_WIDTH(ROB_WIDTH)
    ) dut_rr (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    function automatic logic [31:0] res(input int u, input int c);
        return {16'hC0DE, 4'(u), 12'(c)};
    endfunction

    always_comb begin
        for (int u = 0; u < N_UNIT; u++) begin
            bus_a.unit_result[32*u +: 32] = res(u, cyc);
            bus_b.unit_result[32*u +: 32] = res(u, cyc);
        end
    end

    typedef struct {
        int          bus;
        int          cyc;
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int b, input int c, input int u, input logic [5:0] tag);
        exp_t e;
        int   pos;
        e.bus  = b;
        e.cyc  = c;
        e.tag  = tag;
        e.data = res(u, c);
        pos    = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int b, input logic v, input logic [5:0] t, input logic [31:0] d);
        int idx;
        bit done;
        done = 1'b0;
        idx  = -1;
        while (!done) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].bus == b) begin
                    idx = i;
                    break;
                end
            end
            if (idx >= 0 && sb[idx].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL bcast_missing bus%0d: no broadcast of tag %0d, required at cycle %0d",
                         b, sb[idx].tag, sb[idx].cyc);
                sb.delete(idx);
            end else begin
                done = 1'b1;
            end
        end
        if (v === 1'b1) begin
            n_tests++;
            if (idx < 0 || sb[idx].cyc != cyc) begin
                n_fail++;
                $display("FAIL bcast_unexpected bus%0d: valid with tag %0d at cycle %0d, none required",
                         b, t, cyc);
            end else begin
                if (t !== sb[idx].tag || d !== sb[idx].data) begin
                    n_fail++;
                    $display("FAIL bcast_value bus%0d cycle %0d: got tag %0d data %h, expected tag %0d data %h",
                             b, cyc, t, d, sb[idx].tag, sb[idx].data);
                end
                sb.delete(idx);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.fpr_cdb.valid, bus_a.fpr_cdb.tag, bus_a.fpr_cdb.data);
        mon(1, bus_b.fpr_cdb.valid, bus_b.fpr_cdb.tag, bus_b.fpr_cdb.data);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [2:0] v, input logic [5:0] t0, t1, t2);
        bus_a.req_valid = v;
        bus_a.unit_tag  = {t2, t1, t0};
    endtask

    task automatic drive_b(input logic [2:0] v, input logic [5:0] t0, t1, t2);
        bus_b.req_valid = v;
        bus_b.unit_tag  = {t2, t1, t0};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cycle();
            drive_a(3'b000, 6'd0, 6'd0, 6'd0);
            drive_b(3'b000, 6'd0, 6'd0, 6'd0);
        end
    endtask

    function automatic logic [5:0] tag_of(input int u, input int k);
        return 6'((u << 4) | (k & 15));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        drive_a(3'b000, 6'd0, 6'd0, 6'd0);
        drive_b(3'b000, 6'd0, 6'd0, 6'd0);
        reset = 1'b0;
        #1 reset = 1'b1;

        // Reset state: no grants, no broadcast, even with requests pending
        drive_a(3'b111, 6'd1, 6'd2, 6'd3);
        @(negedge clk);
        chk("reset_ready", bus_a.req_ready, 3'b000);
        chk("reset_valid", bus_a.fpr_cdb.valid, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive_a(3'b000, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        chk("idle_ready", bus_a.req_ready, 3'b000);
        idle(3);

        // Single request, unit2 latency 1
        next_cycle();
        t = cyc;
        drive_a(3'b100, 6'd0, 6'd0, 6'd5);
        @(negedge clk);
        chk("single_ready", bus_a.req_ready, 3'b100);
        push_exp(0, t + 1, 2, 6'd5);
        idle(10);

        // Different latencies granted together
        next_cycle();
        t = cyc;
        drive_a(3'b011, 6'd1, 6'd2, 6'd0);
        @(negedge clk);
        chk("parallel_ready", bus_a.req_ready, 3'b011);
        push_exp(0, t + 2, 0, 6'd1);
        push_exp(0, t + 3, 1, 6'd2);
        idle(10);

        // Slot conflict; unit2 granted while lower-index unit0 is denied
        next_cycle();
        t = cyc;
        drive_a(3'b010, 6'd0, 6'd3, 6'd0);
        @(negedge clk);
        chk("conflict_u1_ready", bus_a.req_ready, 3'b010);
        push_exp(0, t + 3, 1, 6'd3);
        next_cycle();
        drive_a(3'b101, 6'd4, 6'd0, 6'd6);
        @(negedge clk);
        chk("conflict_deny_u0", bus_a.req_ready, 3'b100);
        push_exp(0, t + 2, 2, 6'd6);
        next_cycle();
        drive_a(3'b001, 6'd4, 6'd0, 6'd0);
        @(negedge clk);
        chk("conflict_retry_u0", bus_a.req_ready, 3'b001);
        push_exp(0, t + 4, 0, 6'd4);
        idle(10);

        // Reset while a broadcast is in flight
        next_cycle();
        t = cyc;
        drive_a(3'b010, 6'd0, 6'd7, 6'd0);
        @(negedge clk);
        chk("rstfl_grant", bus_a.req_ready, 3'b010);
        next_cycle();
        reset = 1'b1;
        drive_a(3'b000, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        chk("rstfl_valid_c1", bus_a.fpr_cdb.valid, 1'b0);
        next_cycle();
        drive_a(3'b100, 6'd0, 6'd0, 6'd9);
        @(negedge clk);
        chk("rstfl_ready_in_reset", bus_a.req_ready, 3'b000);
        chk("rstfl_valid_c2", bus_a.fpr_cdb.valid, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive_a(3'b000, 6'd0, 6'd0, 6'd0);
        @(negedge clk);
        chk("rstfl_valid_c3", bus_a.fpr_cdb.valid, 1'b0);
        next_cycle();
        @(negedge clk);
        chk("rstfl_valid_c4", bus_a.fpr_cdb.valid, 1'b0);
        next_cycle();
        t = cyc;
        drive_a(3'b100, 6'd0, 6'd0, 6'd9);
        @(negedge clk);
        chk("rstfl_new_grant", bus_a.req_ready, 3'b100);
        push_exp(0, t + 1, 2, 6'd9);
        idle(10);

        // Saturation: after the first cycle unit1 holds slots 2 and 3 permanently
        for (int k = 0; k < 100; k++) begin
            next_cycle();
            if (k == 0) t = cyc;
            drive_a(3'b111, tag_of(0, k), tag_of(1, k), tag_of(2, k));
            @(negedge clk);
            chk("sat_ready", bus_a.req_ready, (k == 0) ? 3'b111 : 3'b010);
            if (k == 0) begin
                push_exp(0, t + 1, 2, tag_of(2, 0));
                push_exp(0, t + 2, 0, tag_of(0, 0));
                push_exp(0, t + 3, 1, tag_of(1, 0));
            end else begin
                push_exp(0, t + k + 3, 1, tag_of(1, k));
            end
        end
        idle(10);

        // Round-robin among equal-latency units on the all-2 instance
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            if (k == 0) t = cyc;
            drive_b(3'b011, 6'(32 + k), 6'(48 + k), 6'd0);
            @(negedge clk);
            chk("rr_ready", bus_b.req_ready, (k % 2 == 0) ? 3'b001 : 3'b010);
            if (k % 2 == 0) push_exp(1, t + k + 2, 0, 6'(32 + k));
            else            push_exp(1, t + k + 2, 1, 6'(48 + k));
        end
        idle(10);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpr_cdb_arbiter.md
# fpr_cdb_arbiter

Sits downstream of the FP reservation-station/execute units (fadd_fsub, fmul, etc.) and owns the FPR common data bus. Each cycle it grants dispatch to the units whose fixed-latency result slot on the CDB is still free. It carries each granted ROB tag down a slot pipeline and drives `fpr_cdb` (valid, tag, data) exactly when that unit's core result emerges. It guarantees at most one broadcast per cycle and no starvation among units with the same latency.

## Interface
- `N_UNIT`, default 3: number of FP execute units.
- `MAX_LAT`, default 8: deepest supported core latency, in cycles.
- `LATENCY`, default {4'd1, 4'd3, 4'd2}: packed 4-bit per-unit latency; unit i uses `LATENCY[4*i+:4]`, so unit0=2, unit1=3, unit2=1. Each value must be in 1..MAX_LAT; anything else is an elaboration error.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  async active-high reset.
- `req_valid`  in  N_UNIT  unit i has a ready-to-dispatch entry (its `fpr_cdb_req.valid`).
- `req_ready`  out  N_UNIT  grant to unit i (its `fpr_cdb_req.ready`).
- `unit_tag`  in  N_UNIT*ROB_WIDTH  tag of the entry unit i would dispatch this cycle.
- `unit_result`  in  N_UNIT*32  core result outputs, sampled only at broadcast time.
- `fpr_cdb`  out  cdb_t  broadcast bus {valid, tag[ROB_WIDTH], data[32]}.

## Operation
- State:
  - Slot pipeline `slot[1..MAX_LAT]`, each entry {valid, unit index, tag}. `slot[k]` describes the broadcast k cycles from now.
  - Round-robin pointer `rr_ptr`, width clog2(N_UNIT).
- Broadcast:
  - `fpr_cdb.valid = slot[1].valid`.
  - `fpr_cdb.tag = slot[1].tag`.
  - `fpr_cdb.data = unit_result[slot[1].unit]`.
  - When `slot[1]` is invalid, tag and data are don't-care (x).
- Grant (combinational): scan units in order rr_ptr, rr_ptr+1, ... mod N_UNIT. Unit i is granted iff all of:
  - `req_valid[i]`;
  - `slot[L_i+1]` will be free after the shift (`slot[L_i+1]` invalid, or L_i = MAX_LAT);
  - no unit earlier in this scan was granted with the same L_i.
- Several units with different latencies may be granted in the same cycle.
- Each clock edge:
  - Every slot shifts down one position (`slot[k] <= slot[k+1]`; `slot[MAX_LAT]` becomes invalid).
  - Then each granted unit i writes {1, i, `unit_tag[i]`} into `slot[L_i]`.
- `rr_ptr` update: if any unit was granted, it becomes (highest-scan-order granted index + 1) mod N_UNIT; otherwise it holds.
- `req_ready` depends only on state and `req_valid`; it never depends on `fpr_cdb`, so there are no combinational loops with the units.

## Timing
- A grant at cycle t (req_valid & req_ready high at edge t+1) produces `fpr_cdb.valid=1` with that tag during cycle t+L_i. That cycle is the same one in which the unit's core presents the result.
- Throughput: one grant per unit per cycle if no slot conflict. A single unit alone sustains 1 broadcast/cycle.
- Conflict example: unit1 (L=3) granted at t reserves cycle t+3. Unit0 (L=2) requesting at t+1 is denied, because it would also land at t+3. It is granted at t+2 if still valid.
- Boundary cases:
  - Same-latency requesters alternate via rr_ptr.
  - A unit whose slot is free is granted even if a lower-index unit is denied.
  - MAX_LAT slot with nothing behind it is always free after the shift.
- Reset (async, any time):
  - All slots invalid, `rr_ptr`=0.
  - `fpr_cdb.valid`=0 immediately.
  - `req_ready`=0 while reset is high.
  - In-flight broadcasts are dropped; the units are reset on the same signal.
- First grant is possible in the first cycle after reset deasserts.

## Test plan
- Single request: unit2 (L=1) req with tag 5 at cycle 10 → `req_ready[2]`=1 at 10; `fpr_cdb` {1, 5, `unit_result[2]`} at cycle 11 only.
- Different-latency parallel grant: unit0 (L=2, tag 1) and unit1 (L=3, tag 2) both request at cycle 0 → both granted; broadcasts tag 1 at cycle 2 and tag 2 at cycle 3.
- Slot conflict: unit1 (L=3) granted at 0; unit0 (L=2) requests at 1 → denied at 1, granted at 2, broadcasts at 4; cycle 3 broadcasts unit1 only.
- Round-robin (bench override LATENCY all 2): units 0 and 1 request continuously → grants alternate 0,1,0,1; `fpr_cdb` valid every cycle from cycle 2.
- Reset mid-flight: grant unit1 (L=3) at 0, assert reset during cycle 1 → `fpr_cdb.valid`=0 during cycles 1-4; after release, a new unit2 request broadcasts 1 cycle after its grant.
- Saturation: all units request every cycle with default latencies for 100 cycles → never more than one valid broadcast per cycle; every granted tag appears exactly once, at its grant cycle + L.
